// File: rtl/blit_sequencer.sv
// Rectangle command sequencer for the blitter: walks a fill/copy command in
// row-major order into pipeline stage 1, then waits out the pipeline drain.
module blit_sequencer #(
    parameter int unsigned ADDR_W     = 26,
    parameter int unsigned DIM_W      = 12,
    parameter int unsigned PIPE_DEPTH = 4
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_dst_addr,
    input  logic [ADDR_W-1:0] cmd_dst_stride,
    input  logic [ADDR_W-1:0] cmd_src_addr,
    input  logic [ADDR_W-1:0] cmd_src_stride,
    input  logic [DIM_W-1:0]  cmd_width,
    input  logic [DIM_W-1:0]  cmd_height,
    input  logic [7:0]        cmd_color,
    input  logic              stall,
    output logic              p1_valid,
    output logic [1:0]        p1_op,
    output logic [ADDR_W-1:0] p1_dst_addr,
    output logic [ADDR_W-1:0] p1_src_addr,
    output logic [7:0]        p1_color,
    output logic              p1_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = $clog2(PIPE_DEPTH + 1);
    localparam logic [CNT_W-1:0] DRAIN_END = CNT_W'(PIPE_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [DIM_W-1:0]  x, x_nxt, y, y_nxt;
    logic [DIM_W-1:0]  width_q, width_nxt, height_q, height_nxt;
    logic [ADDR_W-1:0] dst_row, dst_row_nxt, src_row, src_row_nxt;
    logic [ADDR_W-1:0] dst_stride_q, dst_stride_nxt, src_stride_q, src_stride_nxt;
    logic [CNT_W-1:0]  drain_cnt, drain_nxt;
    logic              p1_valid_nxt, p1_last_nxt;
    logic [1:0]        p1_op_nxt;
    logic [ADDR_W-1:0] p1_dst_nxt, p1_src_nxt;
    logic [7:0]        p1_color_nxt;
    logic              cmd_ready_nxt, busy_nxt, done_nxt;
    logic              row_end, col_end;

    // State and every registered output
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            x            <= '0;
            y            <= '0;
            width_q      <= '0;
            height_q     <= '0;
            dst_row      <= '0;
            src_row      <= '0;
            dst_stride_q <= '0;
            src_stride_q <= '0;
            drain_cnt    <= '0;
            p1_valid     <= 1'b0;
            p1_last      <= 1'b0;
            p1_op        <= '0;
            p1_dst_addr  <= '0;
            p1_src_addr  <= '0;
            p1_color     <= '0;
            cmd_ready    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            state        <= state_nxt;
            x            <= x_nxt;
            y            <= y_nxt;
            width_q      <= width_nxt;
            height_q     <= height_nxt;
            dst_row      <= dst_row_nxt;
            src_row      <= src_row_nxt;
            dst_stride_q <= dst_stride_nxt;
            src_stride_q <= src_stride_nxt;
            drain_cnt    <= drain_nxt;
            p1_valid     <= p1_valid_nxt;
            p1_last      <= p1_last_nxt;
            p1_op        <= p1_op_nxt;
            p1_dst_addr  <= p1_dst_nxt;
            p1_src_addr  <= p1_src_nxt;
            p1_color     <= p1_color_nxt;
            cmd_ready    <= cmd_ready_nxt;
            busy         <= busy_nxt;
            done         <= done_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt      = state;
        x_nxt          = x;
        y_nxt          = y;
        width_nxt      = width_q;
        height_nxt     = height_q;
        dst_row_nxt    = dst_row;
        src_row_nxt    = src_row;
        dst_stride_nxt = dst_stride_q;
        src_stride_nxt = src_stride_q;
        drain_nxt      = drain_cnt;
        p1_valid_nxt   = p1_valid;
        p1_last_nxt    = p1_last;
        p1_op_nxt      = p1_op;
        p1_dst_nxt     = p1_dst_addr;
        p1_src_nxt     = p1_src_addr;
        p1_color_nxt   = p1_color;
        cmd_ready_nxt  = cmd_ready;
        busy_nxt       = busy;
        done_nxt       = 1'b0;
        row_end        = (x == width_q - DIM_W'(1));
        col_end        = (y == height_q - DIM_W'(1));

        unique case (state)
            S_IDLE: begin
                cmd_ready_nxt = 1'b1;
                busy_nxt      = 1'b0;
                if (cmd_valid) begin
                    width_nxt      = cmd_width;
                    height_nxt     = cmd_height;
                    dst_stride_nxt = cmd_dst_stride;
                    src_stride_nxt = cmd_src_stride;
                    dst_row_nxt    = cmd_dst_addr;
                    src_row_nxt    = cmd_src_addr;
                    x_nxt          = '0;
                    y_nxt          = '0;
                    p1_op_nxt      = cmd_op;
                    p1_color_nxt   = cmd_color;
                    p1_dst_nxt     = cmd_dst_addr;
                    p1_src_nxt     = cmd_src_addr;
                    cmd_ready_nxt  = 1'b0;
                    busy_nxt       = 1'b1;
                    if (cmd_width == '0 || cmd_height == '0) begin
                        // Empty rectangle: nothing enters the pipe, report done at once
                        state_nxt    = S_DRAIN;
                        drain_nxt    = DRAIN_END;
                        done_nxt     = 1'b1;
                        p1_valid_nxt = 1'b0;
                        p1_last_nxt  = 1'b0;
                    end else begin
                        state_nxt    = S_RUN;
                        p1_valid_nxt = 1'b1;
                        p1_last_nxt  = (cmd_width == DIM_W'(1)) && (cmd_height == DIM_W'(1));
                    end
                end
            end
            S_RUN: begin
                if (!stall) begin
                    if (row_end && col_end) begin
                        state_nxt    = S_DRAIN;
                        drain_nxt    = '0;
                        p1_valid_nxt = 1'b0;
                        p1_last_nxt  = 1'b0;
                    end else if (row_end) begin
                        x_nxt       = '0;
                        y_nxt       = y + DIM_W'(1);
                        dst_row_nxt = dst_row + dst_stride_q;
                        src_row_nxt = src_row + src_stride_q;
                        p1_dst_nxt  = dst_row + dst_stride_q;
                        p1_src_nxt  = src_row + src_stride_q;
                        p1_last_nxt = (width_q == DIM_W'(1)) &&
                                      (y + DIM_W'(1) == height_q - DIM_W'(1));
                    end else begin
                        x_nxt       = x + DIM_W'(1);
                        p1_dst_nxt  = dst_row + ADDR_W'(x + DIM_W'(1));
                        p1_src_nxt  = src_row + ADDR_W'(x + DIM_W'(1));
                        p1_last_nxt = col_end && (x + DIM_W'(1) == width_q - DIM_W'(1));
                    end
                end
            end
            S_DRAIN: begin
                if (drain_cnt >= DRAIN_END) begin
                    state_nxt     = S_IDLE;
                    cmd_ready_nxt = 1'b1;
                    busy_nxt      = 1'b0;
                end else if (!stall) begin
                    drain_nxt = drain_cnt + CNT_W'(1);
                    if (drain_cnt + CNT_W'(1) == DRAIN_END) begin
                        state_nxt     = S_IDLE;
                        done_nxt      = 1'b1;
                        cmd_ready_nxt = 1'b1;
                        busy_nxt      = 1'b0;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule
